shift_amount_detector: RTL and testbench

Inverse companion of barrel_shifter_mux: given an original word and a shifted/rotated word, it recovers the shift_val and direction that produced it. It searches one candidate shift amount per cycle, testing left and right in parallel. Operands arrive on a valid/ready input handshake and the result leaves on a valid/ready output handshake. It sits beside the shifter in self-check and decode paths.

---
 rtl/shift_amount_detector_pkg.sv | 17 +
 rtl/shift_amount_detector_if.sv | 27 ++
 rtl/shift_amount_detector_candidate_cmp.sv | 29 ++
 rtl/shift_amount_detector.sv | 114 +++++++++++
 tb/tb_shift_amount_detector.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/shift_amount_detector_pkg.sv
// Shared types and constants for shift_amount_detector.
// Optional search-cycle reporting is enabled by defining SHIFT_DETECT_CYCLES_EN.
package shift_detect_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned DEF_BUSWIDTH   = 16;
  localparam int unsigned DEF_SHIFTWIDTH = 4;

endpackage

// File: rtl/shift_amount_detector_if.sv
// Operand/result handshake bundle for shift_amount_detector.
// master = operand producer / result consumer, slave = the detector.
interface shift_amount_detector_if #(
  parameter int unsigned BUSWIDTH   = 16,
  parameter int unsigned SHIFTWIDTH = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BUSWIDTH-1:0]   orig_in;
  logic [BUSWIDTH-1:0]   shifted_in;
  logic                  rotation;
  logic                  out_valid;
  logic                  out_ready;
  logic                  found;
  logic [SHIFTWIDTH-1:0] shift_val;
  logic                  direction;

  modport master (
    output in_valid, orig_in, shifted_in, rotation, out_ready,
    input  in_ready, out_valid, found, shift_val, direction
  );

  modport slave (
    input  in_valid, orig_in, shifted_in, rotation, out_ready,
    output in_ready, out_valid, found, shift_val, direction
  );
endinterface

// File: rtl/shift_amount_detector_candidate_cmp.sv
// Combinational test of one candidate shift amount k in both directions.
module shift_candidate_cmp #(
  parameter int unsigned BUSWIDTH   = 16,
  parameter int unsigned SHIFTWIDTH = 4
) (
  input  logic [BUSWIDTH-1:0]   orig,
  input  logic [BUSWIDTH-1:0]   shifted,
  input  logic                  rotation,
  input  logic [SHIFTWIDTH-1:0] k,
  output logic                  match_left,
  output logic                  match_right
);
  logic [2*BUSWIDTH-1:0] dbl;
  logic [2*BUSWIDTH-1:0] dbl_l;
  logic [2*BUSWIDTH-1:0] dbl_r;
  logic [BUSWIDTH-1:0]   cand_l;
  logic [BUSWIDTH-1:0]   cand_r;

  // Rotations come from shifting the word concatenated with itself.
  always_comb begin
    dbl    = {orig, orig};
    dbl_l  = dbl << k;
    dbl_r  = dbl >> k;
    cand_l = rotation ? dbl_l[2*BUSWIDTH-1:BUSWIDTH] : (orig << k);
    cand_r = rotation ? dbl_r[BUSWIDTH-1:0]          : (orig >> k);
    match_left  = (cand_l == shifted);
    match_right = (cand_r == shifted);
  end
endmodule

// File: rtl/shift_amount_detector.sv
// Recovers shift amount and direction from an original/shifted word pair,
// one candidate per cycle. SHIFT_DETECT_CYCLES_EN adds the search_cycles port.
module shift_amount_detector
  import shift_detect_pkg::*;
#(
  parameter int unsigned BUSWIDTH   = DEF_BUSWIDTH,
  parameter int unsigned SHIFTWIDTH = DEF_SHIFTWIDTH
) (
  input  logic                clk,
  input  logic                rst,
`ifdef SHIFT_DETECT_CYCLES_EN
  output logic [SHIFTWIDTH:0] search_cycles,
`endif
  shift_amount_detector_if.slave bus
);
  state_t                state, state_nx;
  logic [SHIFTWIDTH-1:0] k;
  logic [BUSWIDTH-1:0]   orig_q;
  logic [BUSWIDTH-1:0]   shifted_q;
  logic                  rot_q;
  logic                  found_q;
  logic [SHIFTWIDTH-1:0] shift_val_q;
  logic                  dir_q;
  logic                  match_left;
  logic                  match_right;
  logic                  last_k;
`ifdef SHIFT_DETECT_CYCLES_EN
  logic [SHIFTWIDTH:0]   cycles_q;
`endif

  shift_candidate_cmp #(
    .BUSWIDTH   (BUSWIDTH),
    .SHIFTWIDTH (SHIFTWIDTH)
  ) u_cmp (
    .orig        (orig_q),
    .shifted     (shifted_q),
    .rotation    (rot_q),
    .k           (k),
    .match_left  (match_left),
    .match_right (match_right)
  );

  assign last_k = (k == SHIFTWIDTH'(BUSWIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      orig_q      <= '0;
      shifted_q   <= '0;
      rot_q       <= 1'b0;
      found_q     <= 1'b0;
      shift_val_q <= '0;
      dir_q       <= DIR_LEFT;
`ifdef SHIFT_DETECT_CYCLES_EN
      cycles_q    <= '0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            orig_q    <= bus.orig_in;
            shifted_q <= bus.shifted_in;
            rot_q     <= bus.rotation;
            k         <= '0;
          end
        end
        SEARCH: begin
          // Left is tested first so it wins any tie at the same k.
          if (match_left || match_right) begin
            found_q     <= 1'b1;
            shift_val_q <= k;
            dir_q       <= match_left ? DIR_LEFT : DIR_RIGHT;
`ifdef SHIFT_DETECT_CYCLES_EN
            cycles_q    <= (SHIFTWIDTH+1)'(k) + 1'b1;
`endif
          end else if (last_k) begin
            found_q     <= 1'b0;
            shift_val_q <= '0;
            dir_q       <= DIR_LEFT;
`ifdef SHIFT_DETECT_CYCLES_EN
            cycles_q    <= (SHIFTWIDTH+1)'(BUSWIDTH);
`endif
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = SEARCH;
      SEARCH:  if (match_left || match_right || last_k) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.found     = found_q;
    bus.shift_val = shift_val_q;
    bus.direction = dir_q;
`ifdef SHIFT_DETECT_CYCLES_EN
    search_cycles = cycles_q;
`endif
  end
endmodule

// File: tb/tb_shift_amount_detector.sv
// Randomised self-checking bench for shift_amount_detector against a bit-index reference model.
module tb_shift_amount_detector;
  localparam int W  = 16;
  localparam int SW = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
`ifdef SHIFT_DETECT_CYCLES_EN
  logic [SW:0] search_cycles;
`endif

  shift_amount_detector_if #(.BUSWIDTH(W), .SHIFTWIDTH(SW)) bus ();

  shift_amount_detector #(.BUSWIDTH(W), .SHIFTWIDTH(SW)) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef SHIFT_DETECT_CYCLES_EN
    .search_cycles (search_cycles),
`endif
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Result bit i takes source bit i-k (left) or i+k (right); out-of-range is zero or wraps.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] o, input int k,
                                             input bit left, input bit rot);
    logic [W-1:0] r;
    int src;
    r = '0;
    for (int i = 0; i < W; i++) begin
      src = left ? i - k : i + k;
      if (rot) r[i] = o[(src + W) % W];
      else if (src >= 0 && src < W) r[i] = o[src];
    end
    return r;
  endfunction

  task automatic run_op(input logic [W-1:0] o, input logic [W-1:0] s,
                        input logic rot, input int hold);
    bit e_found, e_dir;
    int e_k, e_lat, n;
    logic [W-1:0] sv0;
    e_found = 0; e_dir = 0; e_k = 0; e_lat = W;
    for (int k = 0; k < W; k++) begin
      if (ref_shift(o, k, 1, rot) == s) begin
        e_found = 1; e_dir = 0; e_k = k; e_lat = k + 1; break;
      end
      if (ref_shift(o, k, 0, rot) == s) begin
        e_found = 1; e_dir = 1; e_k = k; e_lat = k + 1; break;
      end
    end
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.orig_in    = o;
    bus.shifted_in = s;
    bus.rotation   = rot;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.out_valid) begin
      check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
      return;
    end
    check("latency",   32'(n),             32'(e_lat));
    check("found",     32'(bus.found),     32'(e_found));
    check("shift_val", 32'(bus.shift_val), e_found ? 32'(e_k) : 32'd0);
    check("direction", 32'(bus.direction), 32'(e_dir));
`ifdef SHIFT_DETECT_CYCLES_EN
    check("search_cycles", 32'(search_cycles), 32'(e_lat));
`endif
    sv0 = W'({bus.found, bus.direction, bus.shift_val});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid",  32'(bus.out_valid), 32'd1);
      check("hold_ready",  32'(bus.in_ready),  32'd0);
      check("hold_result", 32'(W'({bus.found, bus.direction, bus.shift_val})), 32'(sv0));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_valid", 32'(bus.out_valid), 32'd0);
    check("release_ready", 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    logic [W-1:0] o, s;
    int k;
    bit rot, left;
    checks = 0;
    failures = 0;
    bus.in_valid = 1'b0;
    bus.orig_in = '0;
    bus.shifted_in = '0;
    bus.rotation = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_found",     32'(bus.found),     32'd0);
    check("rst_shift_val", 32'(bus.shift_val), 32'd0);
    check("rst_direction", 32'(bus.direction), 32'd0);
`ifdef SHIFT_DETECT_CYCLES_EN
    check("rst_cycles",    32'(search_cycles), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h88AB, 16'h1157, 1'b1, 0);
    run_op(16'h9126, 16'h2691, 1'b1, 0);
    run_op(16'h3124, 16'hC490, 1'b0, 0);
    run_op(16'h29CE, 16'h000A, 1'b0, 5);
    run_op(16'h0001, 16'h0003, 1'b1, 0);
    run_op(16'h0000, 16'h0000, 1'b0, 0);

    // Abort mid-search at candidate 5.
    bus.orig_in = 16'h0001; bus.shifted_in = 16'h0003; bus.rotation = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(16'hBEEF, 16'hEEFB, 1'b1, 0);

    for (int t = 0; t < 40; t++) begin
      o    = W'($urandom);
      k    = int'($urandom_range(0, W - 1));
      rot  = 1'($urandom);
      left = 1'($urandom);
      s    = ($urandom_range(0, 3) == 0) ? W'($urandom) : ref_shift(o, k, left, rot);
      run_op(o, s, rot, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
